memory_cycle: RTL and testbench
===============================

Name: memory_cycle

Overview:
- MEM stage of the 5-stage RISC-V pipeline.
- Consumes the EX/MEM register outputs of the execute stage, performs loads and stores on a valid/ack data-memory bus, and produces the MEM/WB pipeline register.
- Handles byte/half/word lane steering, sign/zero extension, and byte enables.
- Stalls upstream stages while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: max ACCESS cycles waiting for dmem_ack; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- RegWriteM  in  1  register write enable from EX/MEM
- MemWriteM  in  1  store enable from EX/MEM
- ResultSrcM  in  3  WB result select from EX/MEM
- RdM  in  5  destination register
- ALUResultM  in  32  effective address / ALU result
- WriteDataM  in  32  store data (rs2)
- PCPlus4M  in  32  PC+4
- luAuiPCM  in  32  LUI/AUIPC result
- InstrM  in  32  instruction; opcode [6:0] and funct3 [14:12] used
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({ALUResultM[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  access complete; rdata valid this cycle
- dmem_rdata  in  32  read word
- StallM  out  1  freeze PC/IF/ID/EX and the EX/MEM register
- bus_error  out  1  one-cycle pulse on timeout
- RegWriteW, ResultSrcW[2:0], RdW[4:0], ALUResultW[31:0], ReadDataW[31:0], PCPlus4W[31:0], luAuiPCW[31:0], InstrW[31:0]  out  MEM/WB register

Behaviour:
- Memory op classification:
  - load = (InstrM[6:0]==7'b0000011).
  - store = MemWriteM.
  - Anything else is a pass-through.
- FSM states: IDLE, ACCESS, DONE. Reset forces IDLE.
- IDLE:
  - Non-memory op: StallM=0; the MEM/WB register loads all fields every cycle, with ReadDataW=0.
  - Memory op: StallM=1 combinationally; the MEM/WB register loads a bubble (RegWriteW=0, InstrW=32'h00000013, RdW=0); next state is ACCESS.
- ACCESS:
  - dmem_req=1. dmem_we, dmem_addr, dmem_be and dmem_wdata are registered and stable until ack.
  - StallM=1; MEM/WB holds the bubble.
  - On dmem_ack: capture the extended load data into an internal register; next state is DONE.
  - Ack with dmem_req=0 is ignored.
- DONE:
  - StallM=0, dmem_req=0.
  - MEM/WB loads the instruction's fields, with ReadDataW = captured data (0 for stores).
  - Next state is IDLE. The next instruction enters M the following cycle; there is no back-to-back issue from DONE.
- Load extension by funct3 and addr[1:0]:
  - LB(000) / LBU(100): selected byte, sign- or zero-extended.
  - LH(001) / LHU(101): half at addr[1], sign- or zero-extended.
  - LW(010): full word.
- Store byte enables:
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{b}}.
  - SH: be = 4'b0011<<{addr[1],1'b0}, wdata = {2{h}}.
  - SW: be = 4'b1111.
  - Loads drive be = 4'b1111.
- Timeout:
  - A counter clears on entering ACCESS and increments each ACCESS cycle.
  - If TIMEOUT_CYCLES != 0 and count reaches TIMEOUT_CYCLES without ack: bus_error=1 for one cycle, dmem_req drops, captured data=0, next state is DONE.
  - If ack arrives in the same cycle as the timeout, the ack wins and bus_error stays 0.
- Reset (any state, including mid-ACCESS):
  - Next cycle: state IDLE, dmem_req=0, StallM=0 (combinationally 0 once the registers clear), bus_error=0.
  - All MEM/WB outputs are 0 except InstrW=0.
  - dmem_* outputs are 0. Counter and capture register are 0.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0, skips ACCESS: IDLE goes to DONE directly, with no dmem_req.
  - Adds output misalign_fault (1 bit), pulsed high in DONE.
  - In DONE, RegWriteW is forced to 0.
- Undefined:
  - No misalign_fault port.
  - Low address bits are ignored for lane selection: halfword uses addr[1], word uses the full word.
  - The access proceeds normally.

Test Plan:
- Reset during ACCESS: assert rst with dmem_req=1 -> next cycle dmem_req=0, StallM=0, RegWriteW=0, state IDLE.
- ADD pass-through: ALUResultM=32'h0000_0010, RdM=5 -> next cycle ALUResultW=32'h10, RdW=5, RegWriteW=1, StallM=0 throughout.
- LB at 32'h1003, rdata=32'h80FF_1234, ack after 3 cycles -> dmem_addr=32'h1000, be=4'b1111, StallM high 4 cycles, ReadDataW=32'hFFFF_FF80. LBU on the same access -> 32'h0000_0080.
- SH at 32'h2002, rs2=32'h0000_BEEF -> dmem_we=1, be=4'b1100, wdata=32'hBEEF_BEEF, ReadDataW=0.
- Timeout with TIMEOUT_CYCLES=4 and no ack -> bus_error pulses once after 4 ACCESS cycles, StallM released the next cycle, ReadDataW=0.
- LW at 32'h3002 with MEM_MISALIGN_TRAP_EN defined -> no dmem_req, misalign_fault=1 for one cycle, RegWriteW=0. With the macro undefined -> dmem_addr=32'h3000 and a normal load.

Source files
------------

// File: rtl/memory_cycle.sv
// memory_cycle: RISC-V MEM stage driving a valid/ack data-memory bus.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module memory_cycle #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [2:0]  ResultSrcM,
  input  logic [4:0]  RdM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] luAuiPCM,
  input  logic [31:0] InstrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        bus_error,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalign_fault,
`endif
  output logic        RegWriteW,
  output logic [2:0]  ResultSrcW,
  output logic [4:0]  RdW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] luAuiPCW,
  output logic [31:0] InstrW
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic        rw;
    logic [2:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [31:0] pc4;
    logic [31:0] lui;
    logic [31:0] ins;
  } wb_t;

  state_t      state_q;
  logic        req_q, we_q, ld_q, berr_q;
  logic [31:0] addr_q, wdata_q, cap_q, cnt_q;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  wb_t         wb_q, wb_d;

  logic        is_load, is_mem, to_hit, flt;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  assign f3      = InstrM[14:12];
  assign off     = ALUResultM[1:0];
  assign is_load = (InstrM[6:0] == 7'b0000011);
  assign is_mem  = is_load | MemWriteM;
  assign to_hit  = (TIMEOUT_CYCLES != 0) &&
                   (cnt_q == TIMEOUT_CYCLES - 1);

`ifdef MEM_MISALIGN_TRAP_EN
  logic fault_q, mis;
  assign mis = ((f3[1:0] == 2'b01) && off[0]) ||
               ((f3[1:0] == 2'b10) && (off != 2'b00));
  assign flt = fault_q;
  assign misalign_fault = fault_q;
`else
  assign flt = 1'b0;
`endif

  function automatic logic [31:0] ext_load(
    input logic [31:0] w,
    input logic [2:0]  f,
    input logic [1:0]  o
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {o, 3'b000});
    h = o[1] ? w[31:16] : w[15:0];
    unique case (f[1:0])
      2'b00:   ext_load = {{24{b[7] & ~f[2]}}, b};
      2'b01:   ext_load = {{16{h[15] & ~f[2]}}, h};
      default: ext_load = w;
    endcase
  endfunction

  // store lane steering; loads always read the whole word
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = WriteDataM;
    if (MemWriteM) begin
      unique case (f3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << off;
          wdata_d = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << {off[1], 1'b0};
          wdata_d = {2{WriteDataM[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      ld_q    <= 1'b0;
      berr_q  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else begin
      berr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (is_mem) begin
            state_q <= ACCESS;
            req_q   <= 1'b1;
            we_q    <= MemWriteM;
            addr_q  <= {ALUResultM[31:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= '0;
            f3_q    <= f3;
            off_q   <= off;
            ld_q    <= is_load;
`ifdef MEM_MISALIGN_TRAP_EN
            if (mis) begin
              state_q <= DONE;
              req_q   <= 1'b0;
              cap_q   <= '0;
              fault_q <= 1'b1;
            end
`endif
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            cap_q   <= ld_q ? ext_load(dmem_rdata, f3_q, off_q) : '0;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (to_hit) begin
            cap_q   <= '0;
            req_q   <= 1'b0;
            berr_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
`ifdef MEM_MISALIGN_TRAP_EN
          fault_q <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // MEM/WB takes the instruction whenever M is not stalled
  always_comb begin
    wb_d = wb_q;
    if (state_q == DONE || (state_q == IDLE && !is_mem)) begin
      wb_d = '{RegWriteM & ~flt, ResultSrcM, RdM, ALUResultM,
               (state_q == DONE) ? cap_q : 32'h0,
               PCPlus4M, luAuiPCM, InstrM};
    end else if (state_q == IDLE) begin
      wb_d     = '0;
      wb_d.ins = 32'h0000_0013;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wb_q <= '0;
    else     wb_q <= wb_d;
  end

  assign StallM     = (state_q == ACCESS) ||
                      (state_q == IDLE && is_mem);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign bus_error  = berr_q;

  assign RegWriteW  = wb_q.rw;
  assign ResultSrcW = wb_q.rs;
  assign RdW        = wb_q.rd;
  assign ALUResultW = wb_q.alu;
  assign ReadDataW  = wb_q.rdat;
  assign PCPlus4W   = wb_q.pc4;
  assign luAuiPCW   = wb_q.lui;
  assign InstrW     = wb_q.ins;

endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: scoreboard bench for the MEM stage.
// Reference model works from load/store rules with plain arithmetic.
module tb_memory_cycle;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegWriteM = 1'b0, MemWriteM = 1'b0;
  logic [2:0]  ResultSrcM = '0;
  logic [4:0]  RdM = '0;
  logic [31:0] ALUResultM = '0, WriteDataM = '0;
  logic [31:0] PCPlus4M = '0, luAuiPCM = '0;
  logic [31:0] InstrM = 32'h13;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        StallM, bus_error;
  logic        RegWriteW;
  logic [2:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W, luAuiPCW, InstrW;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_fault;
`endif

  always #5 clk = ~clk;

  memory_cycle #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .RdM(RdM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .luAuiPCM(luAuiPCM), .InstrM(InstrM),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .StallM(StallM), .bus_error(bus_error),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_fault(misalign_fault),
`endif
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RdW(RdW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .luAuiPCW(luAuiPCW), .InstrW(InstrW)
  );

  typedef struct packed {
    logic        rw;
    logic [2:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [31:0] pc4;
    logic [31:0] lui;
    logic [31:0] ins;
  } wb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          d;
    logic [31:0] rdata;
  } bus_t;

  wb_t  exp_q[$];
  bus_t bus_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   run = 0;

  task automatic check(input string nm,
                       input logic [191:0] act,
                       input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] load_model(input logic [31:0] w,
                                             input logic [2:0] f,
                                             input logic [1:0] a);
    longint v;
    int sh;
    case (f)
      3'b000, 3'b100: begin
        sh = 8 * int'(a);
        v = longint'((w >> sh) & 32'hFF);
        if (f == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        sh = a[1] ? 16 : 0;
        v = longint'((w >> sh) & 32'hFFFF);
        if (f == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] f,
                                     input logic [4:0] r,
                                     input logic [6:0] op);
    return {17'h0, f, r, op};
  endfunction

  task automatic issue(input logic rw, input logic mw,
                       input logic [2:0] rs, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] pc4, input logic [31:0] lui,
                       input logic [31:0] ins, input int d,
                       input logic [31:0] rdw);
    wb_t  e;
    bus_t b;
    logic ld, mem, tmo, mis;
    int   exp_st, st, acc;
    ld  = (ins[6:0] == 7'b0000011);
    mem = ld | mw;
    tmo = (d + 1) > TO;
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = mem && (((ins[13:12] == 2'b01) && alu[0]) ||
                  ((ins[13:12] == 2'b10) && (alu[1:0] != 2'b00)));
`endif
    e = '{rw & ~mis, rs, rd, alu, 32'h0, pc4, lui, ins};
    if (ld && !mis && !tmo) e.rdat = load_model(rdw, ins[14:12], alu[1:0]);
    exp_q.push_back(e);
    if (mem && !mis) begin
      b.we    = mw;
      b.addr  = alu & ~32'h3;
      b.be    = 4'hF;
      b.wdata = wd;
      if (mw && ins[13:12] == 2'b00) begin
        b.be    = 4'(1 << alu[1:0]);
        b.wdata = 32'(wd[7:0]) * 32'h0101_0101;
      end else if (mw && ins[13:12] == 2'b01) begin
        b.be    = alu[1] ? 4'b1100 : 4'b0011;
        b.wdata = 32'(wd[15:0]) * 32'h0001_0001;
      end
      b.d     = d;
      b.rdata = rdw;
      bus_q.push_back(b);
    end
    acc    = (d + 1 < TO) ? d + 1 : TO;
    exp_st = !mem ? 0 : (mis ? 1 : 1 + acc);
    @(posedge clk);
    #2;
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RdM = rd;
    ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc4;
    luAuiPCM = lui; InstrM = ins;
    run = 1;
    st = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!StallM) break;
      st++;
    end
    check("stall_cycles", 192'(st), 192'(exp_st));
`ifdef MEM_MISALIGN_TRAP_EN
    check("misalign_fault", 192'(misalign_fault), 192'(mis));
`endif
  endtask

  int   rk = 0;
  bus_t cur;
  initial begin : responder
    forever begin
      @(negedge clk);
      if (!run) begin
        dmem_ack = 1'b0;
        rk = 0;
      end else if (dmem_req) begin
        if (rk == 0) begin
          if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected: got req=1 expected none");
            cur = '{1'b0, 32'h0, 4'h0, 32'h0, 100, 32'h0};
          end else begin
            cur = bus_q.pop_front();
            check("bus_req", {dmem_we, dmem_addr, dmem_be},
                  {cur.we, cur.addr, cur.be});
            if (cur.we) check("bus_wdata", 192'(dmem_wdata), 192'(cur.wdata));
          end
        end
        rk++;
        dmem_ack   = (rk == cur.d + 1);
        dmem_rdata = cur.rdata;
      end else begin
        if (rk != 0) begin
          check("req_cycles", 192'(rk),
                192'((cur.d + 1 < TO) ? cur.d + 1 : TO));
          check("bus_error", 192'(bus_error), 192'((cur.d + 1) > TO));
          rk = 0;
        end else begin
          check("bus_error_idle", 192'(bus_error), 192'(0));
        end
        dmem_ack   = ($urandom_range(0, 3) == 0);
        dmem_rdata = $urandom;
      end
    end
  end

  bit  have = 0, take = 0;
  wb_t act, e;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!run) begin
        have = 0;
      end else begin
        act = {RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW,
               PCPlus4W, luAuiPCW, InstrW};
        if (have && take) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_extra: got %0h expected nothing", act);
          end else begin
            e = exp_q.pop_front();
            check("wb", 192'(act), 192'(e));
          end
        end else if (have) begin
          check("bubble", {RegWriteW, RdW, InstrW},
                {1'b0, 5'd0, 32'h13});
        end
        take = !StallM;
        have = 1;
      end
    end
  end

  logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [6:0] aop[4] = '{7'h33, 7'h13, 7'h37, 7'h6F};

  initial begin : driver
    logic [31:0] ins;
    int kind;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out",
          {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, StallM,
           bus_error, RegWriteW, ResultSrcW, RdW, ALUResultW},
          192'(0));
    check("reset_wb", {ReadDataW, PCPlus4W, luAuiPCW, InstrW}, 192'(0));
    @(posedge clk);
    #2;
    rst = 0; RegWriteM = 1'b1; RdM = 5'd3;
    ALUResultM = 32'h40; InstrM = mk(3'd2, 5'd3, 7'h03);
    @(negedge clk);
    check("idle_stall", 192'(StallM), 192'(1));
    @(negedge clk);
    check("access_req", {dmem_req, StallM, dmem_addr}, {2'b11, 32'h40});
    rst = 1; RegWriteM = 1'b0; RdM = '0;
    ALUResultM = '0; InstrM = 32'h13;
    @(negedge clk);
    check("rst_mid", {dmem_req, StallM, RegWriteW, InstrW, bus_error},
          192'(0));
    @(posedge clk);
    #2;
    rst = 0;

    issue(1, 0, 3'd0, 5'd5, 32'h10, 32'h0, 32'h104, 32'h0,
          32'h0020_82B3, 0, 32'h0);
    issue(1, 0, 3'd1, 5'd6, 32'h1003, 32'h0, 32'h108, 32'h0,
          mk(3'd0, 5'd6, 7'h03), 2, 32'h80FF_1234);
    issue(1, 0, 3'd1, 5'd7, 32'h1003, 32'h0, 32'h10C, 32'h0,
          mk(3'd4, 5'd7, 7'h03), 2, 32'h80FF_1234);
    issue(0, 1, 3'd0, 5'd0, 32'h2002, 32'h0000_BEEF, 32'h110, 32'h0,
          mk(3'd1, 5'd0, 7'h23), 1, 32'h0);
    issue(1, 0, 3'd1, 5'd8, 32'h44, 32'h0, 32'h114, 32'h0,
          mk(3'd2, 5'd8, 7'h03), 10, 32'hDEAD_BEEF);
    issue(1, 0, 3'd1, 5'd9, 32'h3002, 32'h0, 32'h118, 32'h0,
          mk(3'd2, 5'd9, 7'h03), 0, 32'h1234_5678);
    issue(1, 0, 3'd1, 5'd10, 32'h48, 32'h0, 32'h11C, 32'h0,
          mk(3'd2, 5'd10, 7'h03), 3, 32'hCAFE_F00D);

    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 2);
      ins = $urandom;
      if (kind == 0) begin
        ins[6:0] = aop[$urandom_range(0, 3)];
      end else if (kind == 1) begin
        ins[6:0] = 7'h03;
        ins[14:12] = lf[$urandom_range(0, 4)];
      end else begin
        ins[6:0] = 7'h23;
        ins[14:12] = 3'($urandom_range(0, 2));
      end
      issue(1'($urandom), kind == 2, 3'($urandom), 5'($urandom),
            $urandom, $urandom, $urandom, $urandom, ins,
            $urandom_range(0, 6), $urandom);
    end

    @(negedge clk);
    #1;
    run = 0;
    check("exp_q_empty", 192'(exp_q.size()), 192'(0));
    check("bus_q_empty", 192'(bus_q.size()), 192'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
